fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Stage directly downstream of the fetch unit, upstream of decode.
- Takes the 8-bit PC from fetch and issues instruction-memory reads (1-cycle synchronous memory).
- Buffers returned {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Back-pressures fetch via fetch_adv; discards wrong-path instructions on flush.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width
- INSTR_W, 9, instruction word width
- DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
- f_clk  in  1  stage clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE and begin fetching
- pc_i  in  ADDR_W  current PC from fetch unit
- fetch_adv  out  1  request issued this cycle; fetch unit advances its PC only when 1
- flush  in  1  taken branch/redirect; discard queued and in-flight instructions
- imem_rd_en  out  1  instruction-memory read strobe
- imem_addr  out  ADDR_W  read address (= pc_i when imem_rd_en)
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_rd_en
- de_valid  out  1  head entry valid toward decode
- de_pc  out  ADDR_W  PC of head entry
- de_instr  out  INSTR_W  instruction of head entry
- de_ready  in  1  decode accepts head entry this cycle
- q_count  out  clog2(DEPTH)+1  occupied entries (debug/perf)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; FIFO empty; rd/wr pointers 0; in-flight flag 0. Outputs: fetch_adv=0, imem_rd_en=0, imem_addr=0, de_valid=0, de_pc=0, de_instr=0, q_count=0. Reset mid-operation drops everything, including any in-flight read.
- FSM states:
  - IDLE: no issue. start=1 -> RUN.
  - RUN: may issue. flush=1 -> FLUSH.
  - FLUSH: one cycle, no issue, in-flight response ignored -> RUN.
  - start while not in IDLE is ignored.
- Issue rule (RUN only): imem_rd_en = fetch_adv = (q_count + inflight) < DEPTH and flush=0.
  - imem_addr = pc_i when imem_rd_en=1, else 0.
  - Register inflight_pc <= pc_i and inflight <= imem_rd_en.
- Response: cycle after issue, write {inflight_pc, imem_rdata} at wr_ptr.
  - Suppressed if flush=1 or state=FLUSH.
  - Credit rule guarantees no overflow; writing when full is an assertion failure.
- Dequeue: de_valid = (q_count != 0). Pop when de_valid and de_ready; de_valid=0 with de_ready=1 is a no-op.
- Simultaneous push and pop: q_count unchanged, both pointers advance.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. q_count is a separate counter, saturation impossible by construction.
- de_pc/de_instr reflect the head entry combinationally from FIFO storage; hold stable while de_valid=1 and de_ready=0.
- Flush (cycle N): FIFO cleared at the edge ending N; de_valid=0 from N+1. Response arriving in N or N+1 dropped. No issue in N or N+1. Issue resumes in N+2 with the redirected pc_i. Pop in cycle N with de_ready=1 still completes (decode saw it).
- Latency without bypass: issue cycle T -> data in FIFO and de_valid=1 at T+2.
- Throughput: 1 instr/cycle sustained when de_ready=1 continuously.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined: when FIFO is empty and a response arrives (not flushed), de_valid=1 in the response cycle with de_pc=inflight_pc, de_instr=imem_rdata. If de_ready=1 that cycle, the entry is consumed without being written; otherwise it is written normally. Issue-to-valid latency is 1 cycle.
- Undefined: all responses go through FIFO; latency 2 cycles.

Test Plan:
- Reset/start: rst_n low 3 cycles, then start=1 at pc_i=0x00, de_ready=1. -> All outputs 0 during reset. imem_rd_en=1 addr 0x00 next cycle. de_valid with de_pc=0x00 two cycles after issue (one with FETCHQ_BYPASS_EN). Then one entry per cycle, PCs 0x01, 0x02...
- Backpressure: de_ready=0 from start, imem returns 0x1A0+addr. -> Exactly DEPTH=4 issues (0x00-0x03). fetch_adv=0 thereafter. q_count=4. de_pc holds 0x00. Release de_ready -> pops in order 0x00..0x03, issue resumes at 0x04.
- Flush: queue holding 0x10-0x12 plus read of 0x13 in flight, flush=1 one cycle, pc_i then 0x40. -> 0x13 response dropped. q_count=0 and de_valid=0 next cycle. Next issued addr 0x40, two cycles after flush. 0x40 is first de_pc.
- Simultaneous push/pop at full-1: q_count=3, push and pop same cycle. -> q_count stays 3. Head advances. Pointer wrap 3->0 verified over 10 consecutive entries, order preserved.
- Async reset mid-run: rst_n asserted between clock edges with 2 entries queued and a read in flight. -> de_valid=0 immediately (no clock). State IDLE. After release no issue until start=1.
- Flush coincident with pop: head 0x20, de_ready=1, flush=1. -> 0x20 consumed that cycle. Nothing else delivered until redirected PC arrives.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: fetch-unit PC, instruction-memory read port and decode handshake.
// master = surrounding pipeline and memory, slave = fetch_queue.
interface fetch_queue_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               start;
    logic [ADDR_W-1:0]  pc_i;
    logic               fetch_adv;
    logic               flush;
    logic               imem_rd_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               de_valid;
    logic [ADDR_W-1:0]  de_pc;
    logic [INSTR_W-1:0] de_instr;
    logic               de_ready;
    logic [CNT_W-1:0]   q_count;

    modport master (
        output start, pc_i, flush, imem_rdata, de_ready,
        input  fetch_adv, imem_rd_en, imem_addr, de_valid, de_pc, de_instr, q_count
    );

    modport slave (
        input  start, pc_i, flush, imem_rdata, de_ready,
        output fetch_adv, imem_rd_en, imem_addr, de_valid, de_pc, de_instr, q_count
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: issues I-mem reads under a credit limit and buffers {pc, instr} for decode.
// FETCHQ_BYPASS_EN lets a response reach decode in its arrival cycle when the FIFO is empty.
module fetch_queue #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9,
    parameter int DEPTH   = 4
) (
    input logic          f_clk,
    input logic          rst_n,
    fetch_queue_if.slave fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state, state_nxt;
    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credits;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              issue, resp, push, pop, de_valid;

    always_ff @(posedge f_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fq.start) state_nxt = RUN;
            RUN:     if (fq.flush) state_nxt = FLUSH;
            FLUSH:   state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Queued plus in-flight entries are the credits; this is what keeps the FIFO from overflowing.
    assign credits = {1'b0, count} + (CNT_W+1)'(inflight);
    assign issue   = (state == RUN) && !fq.flush && (credits < (CNT_W+1)'(DEPTH));
    assign resp    = inflight && !fq.flush && (state != FLUSH);

`ifdef FETCHQ_BYPASS_EN
    logic bypass;
    assign bypass   = resp && (count == '0);
    assign de_valid = (count != '0) || bypass;
    assign head     = (count == '0) ? {inflight_pc, fq.imem_rdata} : mem[rd_ptr];
    assign pop      = (count != '0) && fq.de_ready;
    assign push     = resp && !(bypass && fq.de_ready);
`else
    assign de_valid = (count != '0);
    assign head     = mem[rd_ptr];
    assign pop      = de_valid && fq.de_ready;
    assign push     = resp;
`endif

    always_ff @(posedge f_clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight    <= issue;
            inflight_pc <= fq.pc_i;
        end
    end

    always_ff @(posedge f_clk) begin
        if (push) mem[wr_ptr] <= {inflight_pc, fq.imem_rdata};
    end

    // A pop in the flush cycle has already been seen by decode, so clearing covers it.
    always_ff @(posedge f_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (fq.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assert property (@(posedge f_clk) disable iff (!rst_n) !(push && count == CNT_W'(DEPTH)));

    assign fq.fetch_adv  = issue;
    assign fq.imem_rd_en = issue;
    assign fq.imem_addr  = issue ? fq.pc_i : '0;
    assign fq.de_valid   = de_valid;
    assign fq.de_pc      = de_valid ? head.pc : '0;
    assign fq.de_instr   = de_valid ? head.instr : '0;
    assign fq.q_count    = count;
endmodule
